telem_frame_tx: RTL

Telemetry uplink for the Bluetooth car; it carries data in the opposite direction to the command receiver. It snapshots the four ultrasonic distances, the proximity flags and the drive state, builds a checksummed byte frame, and serialises it as UART 8N1 on the module's own TXD line to the phone. Frames start either periodically or on request.

---
 rtl/telem_frame_tx.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/telem_frame_tx.sv
// telem_frame_tx: snapshots car telemetry and sends it as a checksummed UART 8N1 frame.
// Define TELEM_SEQ_EN to insert a frame sequence byte after the A5 5A header.
module telem_frame_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int FRAME_PERIOD = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        send_req,
  input  logic [12:0] distance_data_f,
  input  logic [12:0] distance_data_b,
  input  logic [12:0] distance_data_l,
  input  logic [12:0] distance_data_r,
  input  logic [7:0]  close_flag,
  input  logic [3:0]  state_ctrl,
  output logic        uart_txd,
  output logic        busy,
  output logic        frame_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int PW = $clog2(FRAME_PERIOD + 1);
`ifdef TELEM_SEQ_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int NBODY  = 10 + OFS;
  localparam int NBYTES = NBODY + 3;
  localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(FRAME_PERIOD - 1);
  localparam logic [3:0]    BYTE_LAST = 4'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] per_cnt;
  logic          tick;
  logic          trigger;
  logic          pending;
  logic [BW-1:0] baud_cnt;
  logic          bit_end;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [7:0]    shreg;
  logic [12:0]   s_f, s_b, s_l, s_r;
  logic [7:0]    s_close;
  logic [3:0]    s_state;
  logic [7:0]    body [NBODY];
  logic [7:0]    chk;
  logic [7:0]    cur_byte;
`ifdef TELEM_SEQ_EN
  logic [7:0]    seq_cnt;
`endif

  assign tick    = (per_cnt == PER_LAST);
  assign trigger = tx_en & (tick | send_req);
  assign bit_end = (baud_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_comb begin
    body[OFS+0] = {3'b0, s_f[12:8]};
    body[OFS+1] = s_f[7:0];
    body[OFS+2] = {3'b0, s_b[12:8]};
    body[OFS+3] = s_b[7:0];
    body[OFS+4] = {3'b0, s_l[12:8]};
    body[OFS+5] = s_l[7:0];
    body[OFS+6] = {3'b0, s_r[12:8]};
    body[OFS+7] = s_r[7:0];
    body[OFS+8] = s_close;
    body[OFS+9] = {4'b0, s_state};
`ifdef TELEM_SEQ_EN
    body[0] = seq_cnt;
`endif
    chk = 8'h00;
    for (int i = 0; i < NBODY; i++) begin
      chk = chk + body[i];
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    unique case (1'b1)
      byte_idx == 4'd0:      cur_byte = 8'hA5;
      byte_idx == 4'd1:      cur_byte = 8'h5A;
      byte_idx == BYTE_LAST: cur_byte = chk;
      default:               cur_byte = body[byte_idx - 4'd2];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      uart_txd   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      s_f        <= '0;
      s_b        <= '0;
      s_l        <= '0;
      s_r        <= '0;
      s_close    <= '0;
      s_state    <= '0;
`ifdef TELEM_SEQ_EN
      seq_cnt    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      // A trigger in the start cycle re-arms the request just consumed
      if (state == IDLE && pending) begin
        pending <= trigger;
      end else if (trigger) begin
        pending <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (pending) begin
            s_f      <= distance_data_f;
            s_b      <= distance_data_b;
            s_l      <= distance_data_l;
            s_r      <= distance_data_r;
            s_close  <= close_flag;
            s_state  <= state_ctrl;
            busy     <= 1'b1;
            uart_txd <= 1'b0;
            baud_cnt <= '0;
            byte_idx <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_txd <= cur_byte[0];
            shreg    <= {1'b0, cur_byte[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              uart_txd <= shreg[0];
              shreg    <= {1'b0, shreg[7:1]};
              bit_idx  <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx == BYTE_LAST) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
`ifdef TELEM_SEQ_EN
              seq_cnt    <= seq_cnt + 8'd1;
`endif
              state      <= DONE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              uart_txd <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
